// File: rtl/i2c_slave_stretch_pkg.sv
// Shared types and constants for the clock-stretching I2C responder.
package i2c_slave_stretch_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StWrData,
        StWrAck,
        StRdData,
        StRdAck,
        StWaitStop
    } state_e;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // Position of the R/W flag inside the received address byte
    localparam int unsigned RW_BIT = 0;

    // Majority vote of three samples
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/i2c_slave_stretch_if.sv
// Bus and application signals of the I2C responder, grouped for the top-level port.
interface i2c_slave_stretch_if;
    logic       scl_i;
    logic       scl_oe;
    logic       sda_i;
    logic       sda_oe;
    logic       stretch;
    logic [7:0] tx_data;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;

    modport slave (
        input  scl_i, sda_i, stretch, tx_data,
        output scl_oe, sda_oe, tx_req, rx_data, rx_valid, busy
    );

    modport master (
        output scl_i, sda_i, stretch, tx_data,
        input  scl_oe, sda_oe, tx_req, rx_data, rx_valid, busy
    );
endinterface

// File: rtl/i2c_slave_stretch_sync.sv
// SCL/SDA synchronizer with edge and START/STOP detection.
// Macro I2C_SLV_GLITCH_FILTER_EN adds a 3-sample majority filter (2 clk extra latency).
module i2c_slave_stretch_sync
    import i2c_slave_stretch_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_s,
    output logic o_sda_s,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start_det,
    output logic o_stop_det
);

    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       r_scl_prev;
    logic       r_sda_prev;
    logic       w_scl;
    logic       w_sda;

    // Two-flop synchronizer; idle bus level is high
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i_scl};
            r_sda_sync <= {r_sda_sync[0], i_sda};
        end
    end

`ifdef I2C_SLV_GLITCH_FILTER_EN
    logic [1:0] r_scl_hist;
    logic [1:0] r_sda_hist;
    logic       r_scl_filt;
    logic       r_sda_filt;

    // Majority over the last three synced samples, registered; 1-clk pulses never win
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_scl_hist <= 2'b11;
            r_sda_hist <= 2'b11;
            r_scl_filt <= 1'b1;
            r_sda_filt <= 1'b1;
        end else begin
            r_scl_hist <= {r_scl_hist[0], r_scl_sync[1]};
            r_sda_hist <= {r_sda_hist[0], r_sda_sync[1]};
            r_scl_filt <= maj3(r_scl_hist[1], r_scl_hist[0], r_scl_sync[1]);
            r_sda_filt <= maj3(r_sda_hist[1], r_sda_hist[0], r_sda_sync[1]);
        end
    end

    assign w_scl = r_scl_filt;
    assign w_sda = r_sda_filt;
`else
    assign w_scl = r_scl_sync[1];
    assign w_sda = r_sda_sync[1];
`endif

    // Previous clean levels for edge detection
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    assign o_scl_s     = w_scl;
    assign o_sda_s     = w_sda;
    assign o_scl_rise  = w_scl & ~r_scl_prev;
    assign o_scl_fall  = ~w_scl & r_scl_prev;
    // SCL must be high on both samples so an SDA edge coinciding with an SCL edge is ignored
    assign o_start_det = r_scl_prev & w_scl & r_sda_prev & ~w_sda;
    assign o_stop_det  = r_scl_prev & w_scl & ~r_sda_prev & w_sda;

endmodule

// File: rtl/i2c_slave_stretch.sv
// I2C responder with one 7-bit address, write/read byte streams and clock stretching
// after ACK bits. Optional glitch filter selected by I2C_SLV_GLITCH_FILTER_EN.
module i2c_slave_stretch
    import i2c_slave_stretch_pkg::*;
#(
    parameter logic [6:0] SLV_ADDR = 7'h05
) (
    input logic                clk,
    input logic                rst,
    i2c_slave_stretch_if.slave bus
);

    logic w_scl_s, w_sda_s, w_scl_rise, w_scl_fall, w_start, w_stop;

    i2c_slave_stretch_sync u_sync (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_scl       (bus.scl_i),
        .i_sda       (bus.sda_i),
        .o_scl_s     (w_scl_s),
        .o_sda_s     (w_sda_s),
        .o_scl_rise  (w_scl_rise),
        .o_scl_fall  (w_scl_fall),
        .o_start_det (w_start),
        .o_stop_det  (w_stop)
    );

    state_e     r_state;
    logic [2:0] r_cnt;
    logic       r_full;
    logic [7:0] r_shift;
    logic       r_rw;
    logic       r_mack;
    logic       r_hold;
    logic       r_scl_oe;
    logic       r_sda_oe;
    logic       r_tx_req;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_busy;

    logic [7:0] w_byte;
    logic       w_point;
    logic       w_release;
    logic       w_go;

    assign w_byte    = {r_shift[6:0], w_sda_s};
    // Stretch point: the SCL fall that ends an ACK bit (master NACK on a read is excluded)
    assign w_point   = w_scl_fall & ~r_hold &
                       ((r_state == StAddrAck) | (r_state == StWrAck) |
                        ((r_state == StRdAck) & (r_mack == ACK)));
    assign w_release = r_hold & ~bus.stretch & ~w_scl_s;
    // Leave the ACK bit now, either directly or when a stretch ends
    assign w_go      = (w_point & ~bus.stretch) | w_release;

    // Protocol FSM, bit counter, shifter and stretch control
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_cnt      <= 3'd0;
            r_full     <= 1'b0;
            r_shift    <= 8'h00;
            r_rw       <= 1'b0;
            r_mack     <= ACK;
            r_hold     <= 1'b0;
            r_scl_oe   <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_tx_req   <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            if (w_stop) begin
                r_state  <= StIdle;
                r_busy   <= 1'b0;
                r_sda_oe <= 1'b0;
                r_scl_oe <= 1'b0;
                r_hold   <= 1'b0;
            end else if (w_start) begin
                r_state  <= StAddr;
                r_cnt    <= 3'd0;
                r_full   <= 1'b0;
                r_sda_oe <= 1'b0;
                r_scl_oe <= 1'b0;
                r_hold   <= 1'b0;
            end else if (w_go) begin
                r_hold   <= 1'b0;
                r_scl_oe <= 1'b0;
                r_cnt    <= 3'd0;
                r_full   <= 1'b0;
                if ((r_state == StRdAck) || ((r_state == StAddrAck) && r_rw)) begin
                    // Read reload: MSB goes on the bus while SCL is still low
                    r_state  <= StRdData;
                    r_shift  <= bus.tx_data;
                    r_sda_oe <= ~bus.tx_data[7];
                    r_tx_req <= 1'b1;
                end else begin
                    r_state  <= StWrData;
                    r_sda_oe <= 1'b0;
                end
            end else if (w_point) begin
                // App not ready: release the ACK and hold SCL low
                r_hold   <= 1'b1;
                r_scl_oe <= 1'b1;
                r_sda_oe <= 1'b0;
            end else if (!r_hold) begin
                unique case (r_state)
                    StAddr, StWrData: begin
                        if (w_scl_rise) begin
                            r_shift <= w_byte;
                            r_cnt   <= r_cnt + 3'd1;
                            if (r_cnt == 3'd7) begin
                                r_full <= 1'b1;
                                if (r_state == StWrData) begin
                                    r_rx_data  <= w_byte;
                                    r_rx_valid <= 1'b1;
                                end
                            end
                        end else if (w_scl_fall && r_full) begin
                            r_full <= 1'b0;
                            if (r_state == StWrData) begin
                                r_state  <= StWrAck;
                                r_sda_oe <= 1'b1;
                            end else if (r_shift[7:1] == SLV_ADDR) begin
                                r_state  <= StAddrAck;
                                r_sda_oe <= 1'b1;
                                r_busy   <= 1'b1;
                                r_rw     <= r_shift[RW_BIT];
                            end else begin
                                r_state <= StWaitStop;
                            end
                        end
                    end
                    StRdData: begin
                        if (w_scl_rise) begin
                            r_cnt <= r_cnt + 3'd1;
                            if (r_cnt == 3'd7) begin
                                r_full <= 1'b1;
                            end
                        end else if (w_scl_fall) begin
                            if (r_full) begin
                                r_full   <= 1'b0;
                                r_sda_oe <= 1'b0;
                                r_state  <= StRdAck;
                            end else begin
                                r_sda_oe <= ~r_shift[6];
                                r_shift  <= {r_shift[6:0], 1'b0};
                            end
                        end
                    end
                    StRdAck: begin
                        if (w_scl_rise) begin
                            r_mack <= w_sda_s;
                        end else if (w_scl_fall) begin
                            // Only a NACK reaches here; ACK is taken as a stretch point
                            r_state  <= StWaitStop;
                            r_sda_oe <= 1'b0;
                        end
                    end
                    StAddrAck, StWrAck, StIdle, StWaitStop: begin
                    end
                endcase
            end
        end
    end

    assign bus.scl_oe   = r_scl_oe;
    assign bus.sda_oe   = r_sda_oe;
    assign bus.tx_req   = r_tx_req;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.busy     = r_busy;

endmodule

// File: tb/tb_i2c_slave_stretch.sv
// Bench for i2c_slave_stretch: bit-level I2C master model on an open-drain bus,
// scoreboard of expected rx_valid/tx_req events checked by an independent monitor.
module tb_i2c_slave_stretch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Master drive: 1 = released
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;

    i2c_slave_stretch_if bus ();

    assign bus.scl_i = m_scl & ~bus.scl_oe;
    assign bus.sda_i = m_sda & ~bus.sda_oe;

    i2c_slave_stretch #(.SLV_ADDR(7'h05)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       is_rx;
        logic [7:0] val;
    } exp_t;
    exp_t sb[$];

    int   oe_cnt = 0;
    int   viol   = 0;
    logic p_sda_oe = 1'b0;
    logic p_scl    = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic expect_rx(input logic [7:0] v);
        exp_t e;
        e.is_rx = 1'b1;
        e.val   = v;
        sb.push_back(e);
    endtask

    task automatic expect_tx();
        exp_t e;
        e.is_rx = 1'b0;
        e.val   = 8'h00;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: every rx_valid / tx_req pulse must match the next expected event
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (bus.rx_valid || bus.tx_req)) begin
            if (sb.size() == 0) begin
                check("unexpected_event", {bus.rx_valid, bus.tx_req}, 2'b00);
            end else begin
                e = sb.pop_front();
                check("event_kind", {bus.rx_valid, bus.tx_req}, {e.is_rx, ~e.is_rx});
                if (e.is_rx) check("rx_data", bus.rx_data, e.val);
            end
        end
    end

    // Track stretch length and SDA changes during a steady SCL-high phase
    always @(negedge clk) begin
        if (bus.scl_oe) oe_cnt <= oe_cnt + 1;
        if (!rst && (bus.sda_oe !== p_sda_oe) && bus.scl_i && p_scl) viol <= viol + 1;
        p_sda_oe <= bus.sda_oe;
        p_scl    <= bus.scl_i;
    end

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scl_high();
        int t;
        t = 0;
        m_scl = 1'b1;
        while (bus.scl_i !== 1'b1 && t < 4000) begin
            wait_clk(1);
            t++;
        end
        if (t >= 4000) check("scl_release_timeout", bus.scl_i, 1'b1);
    endtask

    task automatic put_bit(input logic b);
        wait_clk(6);
        m_sda = b;
        wait_clk(6);
        scl_high();
        wait_clk(10);
        m_scl = 1'b0;
    endtask

    task automatic get_bit(output logic b);
        wait_clk(6);
        m_sda = 1'b1;
        wait_clk(6);
        scl_high();
        wait_clk(5);
        b = bus.sda_i;
        wait_clk(5);
        m_scl = 1'b0;
    endtask

    task automatic m_start();
        if (m_scl == 1'b0) begin
            wait_clk(6);
            m_sda = 1'b1;
            wait_clk(6);
            scl_high();
        end
        wait_clk(10);
        m_sda = 1'b0;
        wait_clk(10);
        m_scl = 1'b0;
    endtask

    task automatic m_stop();
        wait_clk(6);
        m_sda = 1'b0;
        wait_clk(6);
        scl_high();
        wait_clk(10);
        m_sda = 1'b1;
        wait_clk(20);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(b[i]);
        get_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(nack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         oe0;
        int         t;
        bus.stretch = 1'b0;
        bus.tx_data = 8'h00;
        wait_clk(5);

        // Reset state
        check("rst_scl_oe", bus.scl_oe, 1'b0);
        check("rst_sda_oe", bus.sda_oe, 1'b0);
        check("rst_rx_data", bus.rx_data, 8'h00);
        check("rst_rx_valid", bus.rx_valid, 1'b0);
        check("rst_tx_req", bus.tx_req, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        rst = 1'b0;
        wait_clk(10);

        // Single-byte write to address 5 (addr byte 0x0A)
        expect_rx(8'h03);
        m_start();
        write_byte(8'h0A, ack);
        check("wr_addr_ack", ack, 1'b0);
        check("wr_busy", bus.busy, 1'b1);
        write_byte(8'h03, ack);
        check("wr_data_ack", ack, 1'b0);
        m_stop();
        check("wr_busy_end", bus.busy, 1'b0);

        // Multi-byte write
        expect_rx(8'hAA);
        expect_rx(8'h55);
        m_start();
        write_byte(8'h0A, ack);
        write_byte(8'hAA, ack);
        check("mw_ack1", ack, 1'b0);
        write_byte(8'h55, ack);
        check("mw_ack2", ack, 1'b0);
        m_stop();

        // Address mismatch: 7'h09 -> byte 0x12, expect NACK and no events
        m_start();
        write_byte(8'h12, ack);
        check("nak_addr", ack, 1'b1);
        check("nak_busy", bus.busy, 1'b0);
        m_stop();

        // Single-byte read of 0xA5 (addr byte 0x0B), master NACKs
        bus.tx_data = 8'hA5;
        expect_tx();
        m_start();
        write_byte(8'h0B, ack);
        check("rd_addr_ack", ack, 1'b0);
        read_byte(d, 1'b1);
        check("rd_byte", d, 8'hA5);
        m_stop();
        check("rd_busy_end", bus.busy, 1'b0);

        // Two-byte read: ACK then NACK, one reload
        bus.tx_data = 8'h3C;
        expect_tx();
        expect_tx();
        m_start();
        write_byte(8'h0B, ack);
        read_byte(d, 1'b0);
        check("rd2_byte1", d, 8'h3C);
        read_byte(d, 1'b1);
        check("rd2_byte2", d, 8'h3C);
        m_stop();

        // Stretch after the address ACK for 1200 clk, then write 0x04
        bus.stretch = 1'b1;
        expect_rx(8'h04);
        m_start();
        write_byte(8'h0A, ack);
        check("st_addr_ack", ack, 1'b0);
        oe0 = oe_cnt;
        fork
            begin
                write_byte(8'h04, ack);
                m_stop();
            end
            begin
                t = 0;
                while (bus.scl_oe !== 1'b1 && t < 200) begin
                    wait_clk(1);
                    t++;
                end
                check("st_scl_oe_seen", bus.scl_oe, 1'b1);
                wait_clk(1200);
                bus.stretch = 1'b0;
            end
        join
        check("st_data_ack", ack, 1'b0);
        check("st_len_ok", ((oe_cnt - oe0) >= 1195) && ((oe_cnt - oe0) <= 1210), 1'b1);
        check("st_rx_data", bus.rx_data, 8'h04);

        // Repeated START after 4 data bits, then a clean write of 0x02
        expect_rx(8'h02);
        m_start();
        write_byte(8'h0A, ack);
        put_bit(1'b1);
        put_bit(1'b0);
        put_bit(1'b1);
        put_bit(1'b1);
        m_start();
        write_byte(8'h0A, ack);
        check("rs_addr_ack", ack, 1'b0);
        write_byte(8'h02, ack);
        check("rs_data_ack", ack, 1'b0);
        m_stop();
        check("rs_rx_data", bus.rx_data, 8'h02);

        // Reset in the middle of a read while SDA is driven low
        bus.tx_data = 8'h00;
        expect_tx();
        m_start();
        write_byte(8'h0B, ack);
        wait_clk(10);
        t = 0;
        while (bus.sda_oe !== 1'b1 && t < 100) begin
            wait_clk(1);
            t++;
        end
        check("rr_sda_driven", bus.sda_oe, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rr_sda_oe", bus.sda_oe, 1'b0);
        check("rr_scl_oe", bus.scl_oe, 1'b0);
        check("rr_busy", bus.busy, 1'b0);
        check("rr_rx_data", bus.rx_data, 8'h00);
        wait_clk(3);
        rst = 1'b0;
        m_stop();
        wait_clk(20);

        check("sb_empty", sb.size(), 0);
        check("sda_change_scl_high", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
